// File: rtl/mux_sel_pipe.sv
// N-way, W-bit registered data selector behind a 2-entry skid buffer.
// It has valid/ready on both sides and flags selects that are out of range.
module mux_sel_pipe #(
  parameter int               NUM_IN  = 4,
  parameter int               WIDTH   = 32,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] ERR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic                    err_sticky,
  input  logic                    err_clr
);

  generate
    if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
      $error("mux_sel_pipe: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  state_e state, state_next;
  entry_t head, tail, cap;
  logic   accept, rel;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign rel       = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cap = '{data: ERR_VAL, sel: select, err: 1'b1};
    for (int k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) begin
        cap.data = data_in[k*WIDTH +: WIDTH];
        cap.err  = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !rel)      state_next = FULL;
        else if (!accept && rel) state_next = EMPTY;
      end
      FULL:    if (rel) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  // NOTE: the two buffer entries are reset because the head drives data_out, which has a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) head <= cap;
        ONE: begin
          if (accept && rel) head <= cap;
          else if (accept)   tail <= cap;
        end
        FULL:    if (rel) head <= tail;
        default: ;
      endcase
    end
  end

  // If a bad accept and err_clr land on the same edge, the set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_sticky <= 1'b0;
    else if (accept && cap.err) err_sticky <= 1'b1;
    else if (err_clr)           err_sticky <= 1'b0;
  end

  assign data_out = head.data;
  assign out_sel  = head.sel;
  assign sel_err  = head.err;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: three configurations run in lockstep from shared stimulus.
// The configurations are 4x32, 3x32 with ERR_VAL, and 16x8.
module tb_mux_sel_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [3:0]  select = '0;
  logic [31:0] chan [16];

  logic [127:0] d4;
  logic [95:0]  d3;
  logic [127:0] d16;

  logic        ir4, ov4, se4, es4;
  logic [31:0] do4;
  logic [1:0]  os4;
  logic        ir3, ov3, se3, es3;
  logic [31:0] do3;
  logic [1:0]  os3;
  logic        ir16, ov16, se16, es16;
  logic [7:0]  do16;
  logic [3:0]  os16;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  exp_t q4[$], q3[$], q16[$];

  always #5 clk = ~clk;

  always_comb begin
    d4 = {chan[3], chan[2], chan[1], chan[0]};
    d3 = {chan[2], chan[1], chan[0]};
    d16 = '0;
    for (int k = 0; k < 16; k++) d16[k*8 +: 8] = chan[k][7:0];
  end

  mux_sel_pipe #(.NUM_IN(4), .WIDTH(32), .SEL_W(2), .ERR_VAL(32'h0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .select(select[1:0]),
    .data_in(d4), .out_valid(ov4), .out_ready(out_ready), .data_out(do4), .out_sel(os4),
    .sel_err(se4), .err_sticky(es4), .err_clr(err_clr));

  mux_sel_pipe #(.NUM_IN(3), .WIDTH(32), .SEL_W(2), .ERR_VAL(32'hDEAD_BEEF)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3), .select(select[1:0]),
    .data_in(d3), .out_valid(ov3), .out_ready(out_ready), .data_out(do3), .out_sel(os3),
    .sel_err(se3), .err_sticky(es3), .err_clr(err_clr));

  mux_sel_pipe #(.NUM_IN(16), .WIDTH(8), .SEL_W(4), .ERR_VAL(8'h00)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .select(select),
    .data_in(d16), .out_valid(ov16), .out_ready(out_ready), .data_out(do16), .out_sel(os16),
    .sel_err(se16), .err_sticky(es16), .err_clr(err_clr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: build the expected word from the select rule on every accept.
  always @(negedge clk) begin
    if (rst_n && in_valid) begin
      if (ir4) q4.push_back('{chan[select[1:0]], {2'b00, select[1:0]}, 1'b0});
      if (ir3) begin
        if (select[1:0] < 2'd3) q3.push_back('{chan[select[1:0]], {2'b00, select[1:0]}, 1'b0});
        else                    q3.push_back('{32'hDEAD_BEEF, {2'b00, select[1:0]}, 1'b1});
      end
      if (ir16) q16.push_back('{{24'h0, chan[select][7:0]}, select, 1'b0});
    end
  end

  always @(negedge rst_n) begin
    q4.delete();
    q3.delete();
    q16.delete();
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_sel;
  logic        prev_err;

  // Monitor: pop and compare whenever a word is released; also hold-stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov4 && out_ready) begin
      if (q4.size() == 0) check("sb4_underflow", 1, 0);
      else begin
        e = q4.pop_front();
        check("sb4_data", {32'h0, do4}, {32'h0, e.data});
        check("sb4_sel", {62'h0, os4}, {60'h0, e.sel});
        check("sb4_err", {63'h0, se4}, {63'h0, e.err});
      end
    end
    if (rst_n && ov3 && out_ready) begin
      if (q3.size() == 0) check("sb3_underflow", 1, 0);
      else begin
        e = q3.pop_front();
        check("sb3_data", {32'h0, do3}, {32'h0, e.data});
        check("sb3_sel", {62'h0, os3}, {60'h0, e.sel});
        check("sb3_err", {63'h0, se3}, {63'h0, e.err});
      end
    end
    if (rst_n && ov16 && out_ready) begin
      if (q16.size() == 0) check("sb16_underflow", 1, 0);
      else begin
        e = q16.pop_front();
        check("sb16_data", {56'h0, do16}, {32'h0, e.data});
        check("sb16_sel", {60'h0, os16}, {60'h0, e.sel});
        check("sb16_err", {63'h0, se16}, {63'h0, e.err});
      end
    end
    if (rst_n && prev_stall) begin
      check("stall_valid", {63'h0, ov4}, 64'h1);
      check("stall_data", {32'h0, do4}, {32'h0, prev_data});
      check("stall_sel", {62'h0, os4}, {62'h0, prev_sel});
      check("stall_err", {63'h0, se4}, {63'h0, prev_err});
    end
    prev_stall <= rst_n && ov4 && !out_ready;
    prev_data  <= do4;
    prev_sel   <= os4;
    prev_err   <= se4;
  end

  initial begin
    for (int k = 0; k < 16; k++) chan[k] = 32'h0A0 + 32'h11 * k;

    // Reset state
    #2;
    check("rst_in_ready", {63'h0, ir4}, 0);
    check("rst_out_valid", {61'h0, ov4, ov3, ov16}, 0);
    check("rst_data_out", {32'h0, do4}, 0);
    check("rst_flags", {58'h0, os4, se4, es4, es3, es16}, 0);
    #10;
    check("in_ready_before_edge", {63'h0, ir4}, 0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_edge", {61'h0, ir4, ir3, ir16}, 64'h7);

    // Single transfer, one-cycle latency
    in_valid = 1'b1; select = 4'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_valid", {63'h0, ov4}, 1);
    check("t1_data", {32'h0, do4}, 32'h0C2);
    check("t1_sel", {62'h0, os4}, 2);
    tick();
    check("t1_drained", {63'h0, ov4}, 0);

    // Backpressure fill
    out_ready = 1'b0;
    in_valid = 1'b1; select = 4'd0;
    tick();
    check("bp_ready_one", {63'h0, ir4}, 1);
    select = 4'd3;
    tick();
    in_valid = 1'b0;
    check("bp_ready_full", {63'h0, ir4}, 0);
    check("bp_head", {32'h0, do4}, 32'h0A0);
    tick(); tick();
    check("bp_head_held", {32'h0, do4}, 32'h0A0);
    out_ready = 1'b1;
    tick();
    check("bp_second", {32'h0, do4}, 32'h0D3);
    check("bp_ready_back", {63'h0, ir4}, 1);
    tick();
    check("bp_empty", {63'h0, ov4}, 0);

    // Continuous stream, accept and release together in ONE
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select = 4'(i % 4);
      tick();
      check("stream_ready", {63'h0, ir4}, 1);
      check("stream_data", {32'h0, do4}, 32'h0A0 + 32'h11 * (i % 4));
    end
    in_valid = 1'b0;
    tick();

    // Out-of-range on the 3-channel instance
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared0", {63'h0, es3}, 0);
    in_valid = 1'b1; select = 4'd3;
    tick();
    in_valid = 1'b0;
    check("err_data", {32'h0, do3}, 32'hDEAD_BEEF);
    check("err_sel_err", {63'h0, se3}, 1);
    check("err_sticky", {63'h0, es3}, 1);
    check("err_none_4way", {62'h0, se4, es4}, 0);
    tick();
    check("err_sticky_hold", {63'h0, es3}, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_alone", {63'h0, es3}, 0);
    in_valid = 1'b1; select = 4'd3; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    check("err_set_wins", {63'h0, es3}, 1);
    tick();

    // Width/channel sweep on the 16-channel instance
    for (int k = 0; k < 16; k++) chan[k] = 32'h10 + k;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      select = 4'(k);
      tick();
      check("sweep_data", {56'h0, do16}, 64'h10 + k);
      check("sweep_sel_err", {63'h0, se16}, 0);
    end
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; select = 4'd1;
    tick(); tick();
    in_valid = 1'b0;
    check("ar_full", {61'h0, ir4, ir3, ir16}, 0);
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid_now", {61'h0, ov4, ov3, ov16}, 0);
    check("ar_data_now", {32'h0, do4}, 0);
    check("ar_ready_now", {63'h0, ir4}, 0);
    out_ready = 1'b1;
    #4 rst_n = 1'b1;
    tick();
    check("ar_ready_after", {63'h0, ir4}, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_stale", {61'h0, ov4, ov3, ov16}, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      select    = 4'($urandom_range(0, 15));
      chan[$urandom_range(0, 15)] = $urandom();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("drain_valid", {61'h0, ov4, ov3, ov16}, 0);
    check("drain_sb", 64'(q4.size() + q3.size() + q16.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N-way, W-bit data selector with a registered output stage and valid/ready handshake on both sides.
- A 2-entry skid buffer decouples producer and consumer, so multi-cycle datapath stages can be stalled without losing a selected word.
- It replaces the fixed 4-input combinational select wherever the selected value must cross a stage boundary, e.g. ALU-source and writeback paths.
- Out-of-range selects are detected and flagged.

Parameters:
- NUM_IN, 4: number of data channels, legal range 2..16.
- WIDTH, 32: data width in bits per channel.
- SEL_W, 2: select width; must satisfy 2^SEL_W >= NUM_IN.
- ERR_VAL, 0: WIDTH-bit value emitted when select >= NUM_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer presents select and data.
- in_ready  out  1  block can accept this cycle.
- select  in  SEL_W  binary channel index.
- data_in  in  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  data_out holds a selected word.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  WIDTH  oldest buffered selected word.
- out_sel  out  SEL_W  select value captured with data_out.
- sel_err  out  1  data_out word came from an out-of-range select.
- err_sticky  out  1  set on any accepted out-of-range select.
- err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state clears immediately on rst_n low.
- Reset values: count=0, out_valid=0, data_out=0, out_sel=0, sel_err=0, err_sticky=0.
- in_ready reset value: in_ready=0 while rst_n is low; in_ready=1 from the first clk edge after rst_n deasserts.
- Accept: a word is accepted on a clk edge when in_valid && in_ready.
  - Captured word = data_in channel[select] if select < NUM_IN.
  - Otherwise captured word = ERR_VAL, with its error bit set.
- Release: the head entry is released on a clk edge when out_valid && out_ready.
- Latency: an accepted word appears on data_out at the next edge when the buffer was empty. There is no combinational path from data_in or select to data_out.
- Buffer: 2 entries, strict FIFO order; entry 0 is the head.
- State machine on count:
  - EMPTY (0): out_valid=0, in_ready=1. Accept moves to ONE.
  - ONE (1): out_valid=1, in_ready=1.
    - Accept with no release: go to FULL.
    - Release with no accept: go to EMPTY.
    - Accept and release together: stay in ONE; the new word becomes the head on the same edge.
  - FULL (2): out_valid=1, in_ready=0. Release moves to ONE and entry 1 shifts to entry 0. No accept is possible.
- in_ready is a registered function of count (in_ready = count<2). It never depends combinationally on out_ready.
- Stall: while out_valid && !out_ready, data_out, out_sel and sel_err must hold stable.
- in_valid low: the select and data_in inputs are don't-care.
- err_sticky: set on the edge that accepts an out-of-range select.
  - err_clr clears it on the edge.
  - If set and clear coincide on the same edge, set wins.
- sel_err travels with its entry; it is not a pulse.
- Reset mid-transfer: all buffered words are discarded. No word is emitted after rst_n rises until a new accept.
- Elaboration: NUM_IN outside 2..16, or 2^SEL_W < NUM_IN, must stop elaboration via a generate-time check.

Test Plan:
- Reset then single transfer: NUM_IN=4, in_valid=1, select=2, channels {A0,B1,C2,D3}=32'h0A0,32'h0B1,32'h0C2,32'h0D3, out_ready=1.
  - Required: data_out=32'h0C2, out_sel=2, out_valid=1 exactly one cycle after accept.
- Backpressure fill: out_ready=0; accept select=0 then select=3.
  - Required: in_ready drops to 0 after the second accept; data_out holds 32'h0A0 stable.
  - Then raise out_ready: 32'h0A0 followed by 32'h0D3, in order, no loss.
- Simultaneous accept/release in ONE: a continuous stream with select cycling 0,1,2,3 and out_ready=1.
  - Required: one word per cycle, in_ready stays 1, output sequence 0A0,0B1,0C2,0D3.
- Out-of-range: NUM_IN=3, SEL_W=2, ERR_VAL=32'hDEAD_BEEF, select=3.
  - Required: data_out=32'hDEADBEEF, sel_err=1, err_sticky=1.
  - err_clr pulsed alone clears err_sticky.
  - err_clr pulsed on the same edge as another bad accept leaves err_sticky at 1.
- Async reset mid-operation: buffer FULL, then rst_n low for half a cycle between edges.
  - Required: out_valid=0 and count=0 immediately, without waiting for a clk edge.
  - in_ready=1 one edge after release.
  - No stale word ever appears.
- Width/channel sweep: NUM_IN=16, WIDTH=8, SEL_W=4; each channel k = 8'h10+k.
  - Required: select k returns 8'h10+k for all k=0..15; no sel_err.
